// File: rtl/aes_kexp_pkg.sv
// Shared encodings, schedule-size helpers and FSM state type for the sequential AES key expander.
package aes_kexp_pkg;

    localparam logic [1:0] KL_128 = 2'd0;
    localparam logic [1:0] KL_192 = 2'd1;
    localparam logic [1:0] KL_256 = 2'd2;

    localparam int unsigned MAX_WORDS = 60;

    typedef enum logic {S_IDLE, S_GEN} state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  nk_of = 4'd6;
            KL_256:  nk_of = 4'd8;
            default: nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  nr_of = 4'd12;
            KL_256:  nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] nt_of(input logic [1:0] kl);
        case (kl)
            KL_192:  nt_of = 6'd52;
            KL_256:  nt_of = 6'd60;
            default: nt_of = 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_kexp_subword.sv
// SubWord with optional RotWord in front: the single S-box bank shared by every schedule step.
module aes_kexp_subword
    import aes_kexp_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic        i_rot,
    output logic [31:0] o_word_c
);

    logic [31:0] w_in;

    assign w_in = i_rot ? {i_word[23:0], i_word[31:24]} : i_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte   (w_in[8*b +: 8]),
            .o_byte_c (o_word_c[8*b +: 8])
        );
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational table lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte_c
);

    // Entry for input x sits at bits [8*(255-x) +: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] w_inv;

    assign w_inv    = ~i_byte;
    assign o_byte_c = SBOX[{w_inv, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expander_seq.sv
// Sequential AES-128/192/256 key expansion, one word per cycle, with a random-access round-key port.
// Define AES_KEY_EXP_INV_EN to add rd_inv (equivalent-inverse-cipher keys via InvMixColumns on read).
module aes_key_expander_seq
    import aes_kexp_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256,
    parameter int unsigned RD_REG       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [1:0]   i_key_len,
    input  logic [255:0] i_key_in,
    output logic         o_ready,
    output logic         o_keys_valid,
    output logic         o_done,
    output logic         o_cfg_err,
    output logic [3:0]   o_nr,
    input  logic [3:0]   i_rd_round,
`ifdef AES_KEY_EXP_INV_EN
    input  logic         i_rd_inv,
`endif
    output logic [127:0] o_rd_key,
    output logic         o_rd_err
);

    localparam logic [1:0] MAX_KL = (MAX_KEY_BITS >= 256) ? KL_256 :
                                    (MAX_KEY_BITS >= 192) ? KL_192 : KL_128;
    localparam int unsigned STORE_WORDS = 32'(nt_of(MAX_KL));

    state_t      r_state;
    logic [31:0] r_w [STORE_WORDS];
    logic [5:0]  r_i;
    logic [2:0]  r_j;
    logic [7:0]  r_rcon;
    logic [1:0]  r_kl;
    logic        r_ready, r_keys_valid, r_done, r_cfg_err;
    logic [3:0]  r_nr;

    logic [3:0]  w_nk;
    logic [5:0]  w_nt;
    logic [31:0] w_prev, w_back, w_sub, w_t, w_new;
    logic        w_rot, w_kl_bad;

    assign w_nk     = nk_of(r_kl);
    assign w_nt     = nt_of(r_kl);
    assign w_prev   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - 6'(w_nk)];
    assign w_rot    = (r_j == 3'd0);
    assign w_kl_bad = (i_key_len == 2'd3) || (i_key_len > MAX_KL);

    aes_kexp_subword u_subword (
        .i_word   (w_prev),
        .i_rot    (w_rot),
        .o_word_c (w_sub)
    );

    always_comb begin
        w_t = w_prev;
        if (r_j == 3'd0) begin
            w_t = w_sub ^ {r_rcon, 24'h0};
        end else if (w_nk == 4'd8 && r_j == 3'd4) begin
            w_t = w_sub;
        end
    end

    assign w_new = w_back ^ w_t;

    // Control FSM, generation counters and word store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_keys_valid <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_nr         <= 4'd0;
            r_i          <= 6'd0;
            r_j          <= 3'd0;
            r_rcon       <= 8'h00;
            r_kl         <= KL_128;
            for (int k = 0; k < int'(STORE_WORDS); k++) begin
                r_w[6'(k)] <= 32'h0;
            end
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_kl_bad) begin
                        r_cfg_err <= 1'b1;
                    end else if (i_start) begin
                        for (int k = 0; k < 8; k++) begin
                            if (4'(k) < nk_of(i_key_len)) begin
                                r_w[6'(k)] <= i_key_in[8'(255 - 32*k) -: 32];
                            end
                        end
                        r_i          <= 6'(nk_of(i_key_len));
                        r_j          <= 3'd0;
                        r_rcon       <= 8'h01;
                        r_kl         <= i_key_len;
                        r_nr         <= nr_of(i_key_len);
                        r_keys_valid <= 1'b0;
                        r_ready      <= 1'b0;
                        r_state      <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_w[r_i] <= w_new;
                    r_i      <= r_i + 6'd1;
                    r_j      <= (r_j == 3'(w_nk - 4'd1)) ? 3'd0 : r_j + 3'd1;
                    if (r_j == 3'd0) begin
                        r_rcon <= xtime(r_rcon);
                    end
                    if (r_i == w_nt - 6'd1) begin
                        r_ready      <= 1'b1;
                        r_keys_valid <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_keys_valid = r_keys_valid;
    assign o_done       = r_done;
    assign o_cfg_err    = r_cfg_err;
    assign o_nr         = r_nr;

`ifdef AES_KEY_EXP_INV_EN
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gm = (c[3] ? x8 : 8'h0) ^ (c[2] ? x4 : 8'h0) ^ (c[1] ? x2 : 8'h0) ^ (c[0] ? b : 8'h0);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        inv_mix_col = {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                       gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                       gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                       gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    endfunction
`endif

    logic [5:0]   w_idx;
    logic         w_rd_err_c;
    logic [127:0] w_rd_key_c;

    assign w_idx = {i_rd_round, 2'b00};

    // Read mux; out-of-range or not-yet-valid reads return zero
    always_comb begin
        w_rd_err_c = !r_keys_valid || (i_rd_round > r_nr);
        w_rd_key_c = 128'h0;
        if (!w_rd_err_c) begin
            w_rd_key_c = {r_w[w_idx], r_w[w_idx + 6'd1], r_w[w_idx + 6'd2], r_w[w_idx + 6'd3]};
`ifdef AES_KEY_EXP_INV_EN
            if (i_rd_inv && i_rd_round != 4'd0 && i_rd_round != r_nr) begin
                w_rd_key_c = {inv_mix_col(w_rd_key_c[127:96]), inv_mix_col(w_rd_key_c[95:64]),
                              inv_mix_col(w_rd_key_c[63:32]),  inv_mix_col(w_rd_key_c[31:0])};
            end
`endif
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o_rd_key <= 128'h0;
                o_rd_err <= 1'b1;
            end else begin
                o_rd_key <= w_rd_key_c;
                o_rd_err <= w_rd_err_c;
            end
        end
    end else begin : g_rd_comb
        assign o_rd_key = w_rd_key_c;
        assign o_rd_err = w_rd_err_c;
    end

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Directed bench for aes_key_expander_seq: FIPS-197 schedules, read-port bounds, cfg_err, reset mid-run.
module tb_aes_key_expander_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         ready, keys_valid, done, cfg_err, rd_err;
    logic [3:0]   nr, rd_round;
    logic [127:0] rd_key;
`ifdef AES_KEY_EXP_INV_EN
    logic         rd_inv;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_key_expander_seq #(.MAX_KEY_BITS(256), .RD_REG(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_key_len    (key_len),
        .i_key_in     (key_in),
        .o_ready      (ready),
        .o_keys_valid (keys_valid),
        .o_done       (done),
        .o_cfg_err    (cfg_err),
        .o_nr         (nr),
        .i_rd_round   (rd_round),
`ifdef AES_KEY_EXP_INV_EN
        .i_rd_inv     (rd_inv),
`endif
        .o_rd_key     (rd_key),
        .o_rd_err     (rd_err)
    );

    typedef struct {
        logic [1:0]   kl;
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         err;
    } vec_t;

    vec_t         vecs [15];
    logic [255:0] keys [3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd_check(input string nm, input logic [3:0] r, input logic [127:0] k, input logic e);
        rd_round = r;
        tick();
        chk({nm, "_key"}, rd_key, k);
        chk({nm, "_err"}, 128'(rd_err), 128'(e));
    endtask

    // Starts an expansion and waits (bounded) for keys_valid; poke=1 also pulses start mid-run
    task automatic run_exp(input logic [1:0] kl, input logic [255:0] key, input bit poke);
        int n;
        key_len = kl;
        key_in  = key;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_kv_clear", 128'(keys_valid), 128'(0));
        chk("accept_ready_low", 128'(ready), 128'(0));
        n = 0;
        while (!keys_valid && n < 80) begin
            if (n == 5) rd_round = 4'd0;
            if (poke && n == 10) begin
                start   = 1'b1;
                key_len = 2'd2;
            end
            if (poke && n == 11) start = 1'b0;
            tick();
            n++;
            if (n == 6) chk("gen_read_err", 128'(rd_err), 128'(1));
        end
        chk("kv_set", 128'(keys_valid), 128'(1));
        chk("done_pulse", 128'(done), 128'(1));
        if (kl != 2'd1) chk("edges_to_valid", 128'(n), (kl == 2'd0) ? 128'd40 : 128'd52);
        chk("nr", 128'(nr), (kl == 2'd0) ? 128'd10 : (kl == 2'd1) ? 128'd12 : 128'd14);
        tick();
        chk("done_clear", 128'(done), 128'(0));
    endtask

`ifdef AES_KEY_EXP_INV_EN
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] imc_model(input logic [127:0] k);
        logic [127:0] r;
        logic [7:0]   m [4][4];
        m[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        m[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
        m[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
        m[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                logic [7:0] s = 8'h0;
                for (int q = 0; q < 4; q++) s ^= gmul(k[127 - 32*c - 8*q -: 8], m[row][q]);
                r[127 - 32*c - 8*row -: 8] = s;
            end
        end
        return r;
    endfunction
`endif

    initial begin
        logic [1:0] cur_kl;

        keys[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        keys[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        keys[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        vecs[0]  = '{2'd0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
        vecs[1]  = '{2'd0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
        vecs[2]  = '{2'd0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
        vecs[3]  = '{2'd0, 4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
        vecs[4]  = '{2'd0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        vecs[5]  = '{2'd0, 4'd11, 128'h0, 1'b1};
        vecs[6]  = '{2'd0, 4'd15, 128'h0, 1'b1};
        vecs[7]  = '{2'd1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, 1'b0};
        vecs[8]  = '{2'd1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b0};
        vecs[9]  = '{2'd1, 4'd13, 128'h0, 1'b1};
        vecs[10] = '{2'd2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b0};
        vecs[11] = '{2'd2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b0};
        vecs[12] = '{2'd2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, 1'b0};
        vecs[13] = '{2'd2, 4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a, 1'b0};
        vecs[14] = '{2'd2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        key_len  = 2'd0;
        key_in   = '0;
        rd_round = 4'd0;
`ifdef AES_KEY_EXP_INV_EN
        rd_inv   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_kv", 128'(keys_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_cfg_err", 128'(cfg_err), 128'(0));
        chk("rst_nr", 128'(nr), 128'(0));
        chk("rst_rd_key", rd_key, 128'h0);
        chk("rst_rd_err", 128'(rd_err), 128'(1));
        rst = 1'b0;
        tick();

        cur_kl = 2'd3;
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].kl != cur_kl) begin
                run_exp(vecs[v].kl, keys[vecs[v].kl], 1'b0);
                cur_kl = vecs[v].kl;
            end
            rd_check($sformatf("vec%0d", v), vecs[v].rnd, vecs[v].key, vecs[v].err);
        end

        // Reserved key_len: pulse cfg_err, keep the AES-256 schedule
        key_len = 2'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_err_pulse", 128'(cfg_err), 128'(1));
        chk("cfg_ready", 128'(ready), 128'(1));
        chk("cfg_kv_kept", 128'(keys_valid), 128'(1));
        chk("cfg_nr_kept", 128'(nr), 128'd14);
        tick();
        chk("cfg_err_clear", 128'(cfg_err), 128'(0));
        rd_check("cfg_keep_r14", 4'd14, vecs[14].key, 1'b0);

        // Restart invalidates, then reset 20 edges into generation
        key_len = 2'd0;
        key_in  = keys[0];
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_kv_clear", 128'(keys_valid), 128'(0));
        repeat (20) tick();
        rst = 1'b1;
        #1;
        chk("midrst_ready", 128'(ready), 128'(1));
        chk("midrst_kv", 128'(keys_valid), 128'(0));
        chk("midrst_nr", 128'(nr), 128'(0));
        chk("midrst_rd_err", 128'(rd_err), 128'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_check("postrst_read", 4'd0, 128'h0, 1'b1);
        run_exp(2'd0, keys[0], 1'b1);
        rd_check("postrst_r10", 4'd10, vecs[4].key, 1'b0);
        rd_check("postrst_r1", 4'd1, vecs[1].key, 1'b0);
        rd_check("postrst_r11", 4'd11, 128'h0, 1'b1);

`ifdef AES_KEY_EXP_INV_EN
        for (int v = 0; v < 5; v++) begin
            rd_inv = 1'b1;
            rd_check($sformatf("inv%0d", v), vecs[v].rnd,
                     (vecs[v].rnd == 4'd0 || vecs[v].rnd == 4'd10) ? vecs[v].key : imc_model(vecs[v].key),
                     1'b0);
            rd_inv = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
